// File: rtl/mem_stage.sv
// Memory-access stage: registers execute results, runs the req/ack data-memory
// transaction for loads and stores, formats load data and emits a write-back packet.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_ALUResult,
  input  logic [31:0] ex_readData2,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_MemRead,
  input  logic        ex_MemWrite,
  input  logic        ex_RegWrite,
  input  logic        ex_MemtoReg,
  input  logic        ex_Branch,
  input  logic [4:0]  ex_rd,
  input  logic        ex_zeroFlag,
  input  logic [31:0] ex_branchTargetAddress,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] branchTarget,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_writeData,
  output logic        misalign
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, next_state;

  logic        is_mem;
  logic        size_byte, size_half;
  logic        misaligned;
  logic        taken;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  logic        cap_load;
  logic        cap_RegWrite;
  logic [4:0]  cap_rd;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_lane;
  logic [31:0] cap_result;

  assign stall = (state == BUSY);

  // Access size comes from funct3[1:0]; loads with unknown encodings fall to word.
  always_comb begin
    is_mem     = ex_MemRead | ex_MemWrite;
    size_byte  = (ex_funct3[1:0] == 2'b00);
    size_half  = (ex_funct3[1:0] == 2'b01);
    misaligned = is_mem && ((size_half && ex_ALUResult[0]) ||
                            (!size_byte && !size_half && (ex_ALUResult[1:0] != 2'b00)));
    taken      = ex_Branch && (((ex_funct3 == 3'b000) && ex_zeroFlag) ||
                               ((ex_funct3 == 3'b001) && !ex_zeroFlag));
    be_calc    = 4'b1111;
    wdata_calc = ex_readData2;
    if (ex_MemWrite) begin
      if (size_byte) begin
        be_calc    = 4'b0001 << ex_ALUResult[1:0];
        wdata_calc = {4{ex_readData2[7:0]}};
      end else if (size_half) begin
        be_calc    = ex_ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{ex_readData2[15:0]}};
      end
    end
  end

  always_comb begin
    case (cap_lane)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = cap_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ex_valid && is_mem && !misaligned) next_state = BUSY;
      BUSY:    if (dmem_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // MemtoReg is implied by MemRead here: loads always write back the formatted data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCSrc        <= 1'b0;
      branchTarget <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      wb_valid     <= 1'b0;
      wb_RegWrite  <= 1'b0;
      wb_rd        <= '0;
      wb_writeData <= '0;
      misalign     <= 1'b0;
      cap_load     <= 1'b0;
      cap_RegWrite <= 1'b0;
      cap_rd       <= '0;
      cap_funct3   <= '0;
      cap_lane     <= '0;
      cap_result   <= '0;
    end else begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      PCSrc       <= 1'b0;
      misalign    <= 1'b0;
      if (state == IDLE && ex_valid) begin
        if (is_mem && !misaligned) begin
          dmem_req     <= 1'b1;
          dmem_we      <= ex_MemWrite;
          dmem_addr    <= {ex_ALUResult[31:2], 2'b00};
          dmem_be      <= be_calc;
          dmem_wdata   <= wdata_calc;
          cap_load     <= ex_MemRead & ~ex_MemWrite & (ex_MemtoReg | 1'b1);
          cap_RegWrite <= ex_RegWrite;
          cap_rd       <= ex_rd;
          cap_funct3   <= ex_funct3;
          cap_lane     <= ex_ALUResult[1:0];
          cap_result   <= ex_ALUResult;
        end else begin
          wb_valid     <= 1'b1;
          wb_RegWrite  <= ex_RegWrite & ~misaligned;
          wb_rd        <= ex_rd;
          wb_writeData <= ex_ALUResult;
          misalign     <= misaligned;
          if (ex_Branch && !is_mem) begin
            PCSrc        <= taken;
            branchTarget <= ex_branchTargetAddress;
          end
        end
      end else if (state == BUSY && dmem_ack) begin
        dmem_req     <= 1'b0;
        dmem_we      <= 1'b0;
        wb_valid     <= 1'b1;
        wb_RegWrite  <= cap_RegWrite;
        wb_rd        <= cap_rd;
        wb_writeData <= cap_load ? load_data : cap_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against an arithmetic reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_ALUResult, ex_readData2, ex_branchTargetAddress;
  logic [2:0]  ex_funct3;
  logic        ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch, ex_zeroFlag;
  logic [4:0]  ex_rd;
  logic        stall, PCSrc, dmem_req, dmem_we, dmem_ack, wb_valid, wb_RegWrite, misalign;
  logic [31:0] branchTarget, dmem_addr, dmem_wdata, dmem_rdata, wb_writeData;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_rd;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ALUResult(ex_ALUResult),
    .ex_readData2(ex_readData2), .ex_funct3(ex_funct3), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
    .ex_Branch(ex_Branch), .ex_rd(ex_rd), .ex_zeroFlag(ex_zeroFlag),
    .ex_branchTargetAddress(ex_branchTargetAddress), .stall(stall), .PCSrc(PCSrc),
    .branchTarget(branchTarget), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_writeData(wb_writeData),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned access_bytes(input logic [2:0] f3, input logic is_store);
    if (is_store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input int unsigned sz, input logic [31:0] a, input logic is_store);
    int unsigned lane = a % 4;
    if (!is_store || sz == 4) return 4'hF;
    if (sz == 1) return 4'(1 << lane);
    return (lane >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] model_wdata(input int unsigned sz, input logic [31:0] d);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    int unsigned sz = access_bytes(f3, 1'b0);
    logic [31:0] v = rdata >> ((a % 4) * 8);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Issues one instruction from an IDLE cycle and checks everything until its write-back.
  task automatic run_op(input logic mr, input logic mw, input logic rw, input logic br,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] tgt, input logic z, input logic [4:0] rd,
                        input int unsigned dly, input logic [31:0] rdata);
    logic        is_mem = mr | mw;
    int unsigned sz     = access_bytes(f3, mw);
    logic        al     = !is_mem || ((alu % sz) == 0);
    logic        tk     = br && ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z));
    int unsigned stalls = 0;
    ex_MemRead = mr; ex_MemWrite = mw; ex_RegWrite = rw; ex_MemtoReg = mr; ex_Branch = br;
    ex_funct3 = f3; ex_ALUResult = alu; ex_readData2 = wd; ex_branchTargetAddress = tgt;
    ex_zeroFlag = z; ex_rd = rd; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (is_mem && al) begin
      check("req", dmem_req, 1);
      check("we", dmem_we, mw);
      check("addr", dmem_addr, alu - (alu % 4));
      check("be", dmem_be, model_be(sz, alu, mw));
      if (mw) check("wdata", dmem_wdata, model_wdata(sz, wd));
      check("no_wb_busy", wb_valid, 0);
      for (int i = 0; i < int'(dly); i++) begin
        if (stall) stalls++;
        check("req_hold", dmem_req, 1);
        @(posedge clk); #1;
      end
      if (stall) stalls++;
      dmem_ack = 1'b1; dmem_rdata = rdata;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      check("stall_cycles", stalls, dly + 1);
      check("wb_valid_mem", wb_valid, 1);
      check("wb_rw_mem", wb_RegWrite, rw);
      check("wb_rd_mem", wb_rd, rd);
      if (mr) check("load_data", wb_writeData, model_load(f3, alu, rdata));
      check("stall_done", stall, 0);
      check("req_done", dmem_req, 0);
    end else begin
      check("wb_valid", wb_valid, 1);
      check("wb_rd", wb_rd, rd);
      check("wb_rw", wb_RegWrite, is_mem ? 0 : rw);
      check("misalign", misalign, is_mem);
      if (!is_mem) check("wb_data", wb_writeData, alu);
      check("pcsrc", PCSrc, tk);
      if (tk) check("btarget", branchTarget, tgt);
      check("no_req", dmem_req, 0);
      check("stall_idle", stall, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    ex_ALUResult = '0; ex_readData2 = '0; ex_branchTargetAddress = '0; ex_funct3 = '0;
    ex_MemRead = 0; ex_MemWrite = 0; ex_RegWrite = 0; ex_MemtoReg = 0; ex_Branch = 0;
    ex_zeroFlag = 0; ex_rd = '0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_req", dmem_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_writeData, 0);
    check("rst_btarget", branchTarget, 0);
    check("rst_misalign", misalign, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    run_op(0, 0, 1, 0, 3'd0, 32'h0000_1234, 0, 0, 0, 5'd5, 0, 0);
    run_op(1, 0, 1, 0, 3'd0, 32'h0000_0103, 0, 0, 0, 5'd6, 2, 32'h80FF_FF7F);
    run_op(1, 0, 1, 0, 3'd4, 32'h0000_0103, 0, 0, 0, 5'd7, 2, 32'h80FF_FF7F);
    run_op(0, 1, 0, 0, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 0, 0, 5'd0, 0, 0);
    run_op(1, 0, 1, 0, 3'd2, 32'h0000_0006, 0, 0, 0, 5'd8, 0, 0);
    run_op(0, 0, 0, 1, 3'd0, 32'h0, 0, 32'h40, 1, 5'd0, 0, 0);
    @(posedge clk); #1;
    check("pcsrc_pulse", PCSrc, 0);
    check("idle_no_wb", wb_valid, 0);
    run_op(0, 0, 0, 1, 3'd1, 32'h0, 0, 32'h80, 1, 5'd0, 0, 0);

    // Back-to-back ALU ops keep wb_valid high every cycle
    for (int i = 0; i < 4; i++)
      run_op(0, 0, 1, 0, 3'($urandom), $urandom, 0, 0, 0, 5'($urandom), 0, 0);

    // Reset while BUSY, then a late ack
    ex_MemRead = 1; ex_MemWrite = 0; ex_funct3 = 3'd2; ex_ALUResult = 32'h100; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    check("busy_before_rst", stall, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_req_drop", dmem_req, 0);
    check("rst_busy_stall", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("late_ack_wb", wb_valid, 0);
    check("late_ack_stall", stall, 0);
    @(posedge clk); #1;
    check("late_ack_wb2", wb_valid, 0);
    run_op(1, 0, 1, 0, 3'd1, 32'h0000_0302, 0, 0, 0, 5'd9, 1, 32'h8001_7FFF);

    // Randomized mix
    for (int n = 0; n < 80; n++) begin
      int unsigned kind = $urandom_range(0, 3);
      logic [31:0] a = $urandom;
      case (kind)
        0: run_op(0, 0, 1'($urandom), 0, 3'($urandom), a, 0, 0, 0, 5'($urandom), 0, 0);
        1: run_op(0, 0, 0, 1, 3'($urandom_range(0, 2)), a, 0, $urandom, 1'($urandom),
                  5'($urandom), 0, 0);
        2: run_op(1, 0, 1'($urandom), 0, 3'($urandom), a, 0, 0, 0, 5'($urandom),
                  $urandom_range(0, 3), $urandom);
        default: run_op(0, 1, 1'($urandom), 0, 3'($urandom_range(0, 2)), a, $urandom, 0, 0,
                        5'($urandom), $urandom_range(0, 3), 0);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check("gap_no_wb", wb_valid, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
